fifo_8: RTL
===========

FIFO_8 -- requirements
Module: fifo_8

Interface
REQ-001 Parameters: none; depth fixed at 8 entries, data width fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 wr_en  input  1  push request for wr_data this cycle.
REQ-005 wr_data  input  32  word to push.
REQ-006 rd_en  input  1  pop request for the head word this cycle.
REQ-007 rd_data  output  32  head word, show-ahead (valid while empty=0).
REQ-008 full  output  1  high when count==8.
REQ-009 empty  output  1  high when count==0.
REQ-010 count  output  4  number of stored words, 0..8.
REQ-011 overflow  output  1  sticky: push attempted while full.
REQ-012 underflow  output  1  sticky: pop attempted while empty.

Function
REQ-013 Storage: eight 32-bit registers mem[0..7], a 3-bit write pointer wr_ptr, a 3-bit read pointer rd_ptr and a 4-bit count register.
REQ-014 Push accepted iff wr_en=1 and full=0, using full as registered at the start of the cycle; an accepted push writes mem[wr_ptr] and sets wr_ptr to wr_ptr+1 mod 8.
REQ-015 Pop accepted iff rd_en=1 and empty=0, using registered state; an accepted pop sets rd_ptr to rd_ptr+1 mod 8.
REQ-016 Pointer wrap: 7 -> 0, with no extra cycle or bubble.
REQ-017 count: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
REQ-018 Full with wr_en=1 and rd_en=1: pop accepted, push rejected, overflow set, count becomes 7.
REQ-019 Empty with wr_en=1 and rd_en=1: push accepted, pop rejected, underflow set, count becomes 1.
REQ-020 Neither full nor empty with both requests: both accepted, count unchanged.
REQ-021 full, empty and count are decoded combinationally from the count register only.
REQ-022 rd_data = mem[rd_ptr] combinationally when empty=0; rd_data = 32'h0 when empty=1.
REQ-023 Latency: a word pushed in cycle N appears on rd_data in cycle N+1 if the FIFO was empty.
REQ-024 Rejected requests leave mem, pointers and count untouched.
REQ-025 overflow and underflow set on the first offending cycle and stay high until reset.

Reset
REQ-026 While reset=1, asynchronously and regardless of clock: wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
REQ-027 Outputs during and after reset: empty=1, full=0, count=0, rd_data=32'h0.
REQ-028 mem contents are not required to reset; they are never observable while empty=1.
REQ-029 Reset asserted mid-traffic discards all stored words; on the first edge after deassertion the block accepts pushes normally.

Structure
REQ-030 No shared package; depth and width are local constants.
REQ-031 The read path instantiates the existing mux_8 (32-bit, 3-bit select): select=rd_ptr, in0..in7=mem[0..7]; the empty gating to 0 is applied after the mux.
REQ-032 Pointers, count, flag logic and the write decoder are in this module; no other sub-modules.

Verification
REQ-033 Reset -> push 32'hA0..32'hA7 on 8 consecutive cycles -> full=1, count=8; pop 8 -> rd_data sequence A0..A7, then empty=1, rd_data=0.
REQ-034 Wrap: push 5, pop 5, push 8 (32'h10..32'h17) -> wr_ptr wraps 7->0; pops return 10..17 in order; no flag set.
REQ-035 Full, push 32'hDEAD with simultaneous pop -> head popped, DEAD dropped, overflow=1, count=7.
REQ-036 Empty, push 32'h55 with simultaneous pop -> underflow=1, count=1, rd_data=32'h55 next cycle.
REQ-037 Count=3, push and pop together for 10 cycles -> count stays 3, output order preserved.
REQ-038 Reset asserted between clock edges with count=6 -> count=0, empty=1 immediately; next push 32'h77 -> rd_data=32'h77 one cycle later.

Source files
------------

// File: rtl/mux_8.sv
// Eight-input, 32-bit-wide multiplexer with a 3-bit select.
module mux_8 (
    input  logic [2:0]  i_sel,
    input  logic [31:0] i_in0,
    input  logic [31:0] i_in1,
    input  logic [31:0] i_in2,
    input  logic [31:0] i_in3,
    input  logic [31:0] i_in4,
    input  logic [31:0] i_in5,
    input  logic [31:0] i_in6,
    input  logic [31:0] i_in7,
    output logic [31:0] o_data
);

    always_comb begin
        // NOTE: a default assignment first keeps this block free of inferred latches.
        o_data = i_in0;
        case (i_sel)
            3'd1:    o_data = i_in1;
            3'd2:    o_data = i_in2;
            3'd3:    o_data = i_in3;
            3'd4:    o_data = i_in4;
            3'd5:    o_data = i_in5;
            3'd6:    o_data = i_in6;
            3'd7:    o_data = i_in7;
            default: o_data = i_in0;
        endcase
    end

endmodule

// File: rtl/fifo_8.sv
// Eight-entry, 32-bit show-ahead FIFO with sticky overflow/underflow flags.
module fifo_8 (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        full,
    output logic        empty,
    output logic [3:0]  count,
    output logic        overflow,
    output logic        underflow
);

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [2:0]       r_wr_ptr;
    logic [2:0]       r_rd_ptr;
    logic [3:0]       r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_mux_data;

    assign w_full  = (r_count == 4'd8);
    assign w_empty = (r_count == 4'd0);
    assign w_push  = wr_en && !w_full;
    assign w_pop   = rd_en && !w_empty;

    // NOTE: storage has no reset; a word is only visible after a push has written it.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wr_ptr == 3'(i))) begin
                r_mem[i] <= wr_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= 3'd0;
            r_rd_ptr    <= 3'd0;
            r_count     <= 4'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 3'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 3'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full)  r_overflow  <= 1'b1;
            if (rd_en && w_empty) r_underflow <= 1'b1;
        end
    end

    mux_8 u_rd_mux (
        .i_sel  (r_rd_ptr),
        .i_in0  (r_mem[0]),
        .i_in1  (r_mem[1]),
        .i_in2  (r_mem[2]),
        .i_in3  (r_mem[3]),
        .i_in4  (r_mem[4]),
        .i_in5  (r_mem[5]),
        .i_in6  (r_mem[6]),
        .i_in7  (r_mem[7]),
        .o_data (w_mux_data)
    );

    // Gate after the mux so stale storage never leaks out while empty.
    assign rd_data   = w_empty ? '0 : w_mux_data;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
